avalon_mem_bist_master: RTL and testbench
=========================================

Name: avalon_mem_bist_master

Overview:
- Avalon-MM master that exercises the on-chip RAM slave from the other end of the bus.
- On `start` it writes a deterministic pattern over a word range, then reads the range back and compares each word.
- It reports pass/fail, an error count and the first failing address.
- It sits beside the Nios II data master in the Qsys system and gives the RAM a self-test at bring-up.

Parameters:
- ADDR_W, 14, word-address width of the slave port.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, fixed slave read latency in clocks, counted from the cycle the read is accepted. Legal range 1..4.
- ERR_W, 16, width of the error counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a test when idle
- base_addr  in  ADDR_W  first word address, sampled on start
- length  in  ADDR_W+1  number of words, sampled on start
- seed  in  DATA_W  pattern seed, sampled on start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at test completion
- pass  out  1  result of the last test; held until the next start
- error_count  out  ERR_W  number of mismatches in the last test, saturating
- first_fail_addr  out  ADDR_W  address of the first mismatch in the last test
- avm_address  out  ADDR_W  word address
- avm_chipselect  out  1  bus strobe
- avm_write  out  1  write request
- avm_read  out  1  read request
- avm_byteenable  out  DATA_W/8  always all ones while a request is asserted, 0 otherwise
- avm_writedata  out  DATA_W  write data
- avm_readdata  in  DATA_W  read data
- avm_waitrequest  in  1  slave stall

Behaviour:
- Clock and reset: one clock domain, `clk`. Reset is asynchronous and active-low on `reset_n`.
- Reset values:
  - All avm_* strobes are 0; avm_address and avm_writedata are 0.
  - busy=0, done=0, pass=0, error_count=0, first_fail_addr=0.
  - FSM is in IDLE.
- Reset mid-operation: bus strobes drop in the same instant (asynchronous). No partial result is retained.
- Pattern: word i (0-based) = seed + i, modulo 2^DATA_W.
- Addressing: word i is at (base_addr + i) mod 2^ADDR_W, so the range wraps at the top of the address space.
- FSM states: IDLE, WR, RD_REQ, RD_WAIT, FIN.
- IDLE:
  - On start, latch base_addr, length and seed; clear error_count and first_fail_addr; set busy.
  - If length==0, go to FIN; otherwise go to WR with i=0.
  - start while busy is ignored.
- WR:
  - Assert chipselect=1, write=1, address and writedata for word i.
  - Hold every avm_* output stable while avm_waitrequest=1.
  - On a cycle with waitrequest=0 the beat is accepted and i increments.
  - After the last beat, i=0 and go to RD_REQ. Back-to-back writes are allowed, one per accepted cycle.
- RD_REQ:
  - Assert chipselect=1, read=1, address for word i; hold while waitrequest=1.
  - When accepted, deassert read and go to RD_WAIT.
  - Only one read is outstanding at a time.
- RD_WAIT:
  - Count READ_LATENCY cycles after acceptance, then sample avm_readdata (with READ_LATENCY=1 this is the cycle after acceptance).
  - Compare against the pattern for word i.
  - On mismatch, error_count increments, saturating at 2^ERR_W-1. If this is the first mismatch, record first_fail_addr.
  - Then i increments. Go to RD_REQ if words remain, else FIN.
- FIN: done=1 for exactly one cycle; busy=0 in that same cycle; pass=(error_count==0); return to IDLE.
- Zero-length test: busy stays high 1 cycle (start → busy next cycle), then done with pass=1, and no bus activity occurs.
- length > 2^ADDR_W is clamped to 2^ADDR_W.
- avm_readdata is ignored outside the sample cycle.

Optional Feature:
- Macro: AVALON_MEM_BIST_INVERT_PASS_EN.
- Defined:
  - After the first read-back pass, a second write pass and a second read pass run over the same range with pattern ~(seed+i).
  - Errors from both passes accumulate in error_count; first_fail_addr is the first mismatch in either pass.
  - FSM adds a 1-bit pass index; done fires only after the second read pass.
- Undefined: single write/read pass only; no extra state or logic.

Test Plan:
- Ideal slave (waitrequest=0, latency 1), base=0x0010, length=4, seed=0xA5A50000:
  - Writes 0xA5A50000..0xA5A50003 to 0x10..0x13 on 4 consecutive cycles.
  - Then 4 reads, each taking 2 cycles.
  - Then done pulse with pass=1, error_count=0.
- Same setup, but the slave model forces word 0x12 to read 0:
  - pass=0, error_count=1, first_fail_addr=0x0012.
- Random waitrequest (50%):
  - avm_* held stable on every stalled cycle (assertion).
  - Every word is written exactly once, and the final result is pass=1.
- base=0x3FFE, length=4:
  - Addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001 in order.
- length=0:
  - No chipselect ever asserted; done 1 cycle after busy rises; pass=1.
- reset_n low during WR beat 2:
  - Strobes are 0 immediately; busy=0, pass=0.
  - After release, a new start runs a full clean test.

Source files
------------

// File: rtl/avalon_mem_bist_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | avalon_mem_bist_master                                                   |
// | Avalon-MM master that writes seed+i over a word range, reads it back and |
// | reports pass/fail, error count and first failing address.                |
// | Optional: AVALON_MEM_BIST_INVERT_PASS_EN adds a ~(seed+i) second pass.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module avalon_mem_bist_master #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int ERR_W        = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    error_count,
  output logic [ADDR_W-1:0]   first_fail_addr,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic                avm_read,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
);

  localparam int              BE_W      = DATA_W / 8;
  localparam logic [ADDR_W:0] C_MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [2:0]      C_LAT     = 3'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_len;
  logic [DATA_W-1:0]   r_seed;
  logic [ADDR_W:0]     r_idx;
  logic [2:0]          r_lat;
  logic [ADDR_W:0]     w_len_clamped;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_pattern;
  logic                w_last;
  logic                w_sample;
  logic                w_mismatch;
`ifdef AVALON_MEM_BIST_INVERT_PASS_EN
  logic                r_pass_idx;
`endif

  assign w_len_clamped = (length > C_MAX_LEN) ? C_MAX_LEN : length;
  assign w_addr        = r_base + r_idx[ADDR_W-1:0];
  assign w_last        = ((r_idx + 1'b1) == r_len);
  assign w_mismatch    = (avm_readdata != w_pattern);

`ifdef AVALON_MEM_BIST_INVERT_PASS_EN
  assign w_pattern = r_pass_idx ? ~(r_seed + DATA_W'(r_idx)) : (r_seed + DATA_W'(r_idx));
`else
  assign w_pattern = r_seed + DATA_W'(r_idx);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Bus strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    w_next_state   = r_state;
    avm_chipselect = 1'b0;
    avm_write      = 1'b0;
    avm_read       = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    avm_byteenable = '0;
    w_sample       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = (length == '0) ? S_FIN : S_WR;
      end
      S_WR: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_address    = w_addr;
        avm_writedata  = w_pattern;
        avm_byteenable = {BE_W{1'b1}};
        if (!avm_waitrequest && w_last) w_next_state = S_RD_REQ;
      end
      S_RD_REQ: begin
        avm_chipselect = 1'b1;
        avm_read       = 1'b1;
        avm_address    = w_addr;
        avm_byteenable = {BE_W{1'b1}};
        if (!avm_waitrequest) w_next_state = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (r_lat == C_LAT) begin
          w_sample = 1'b1;
          if (!w_last) begin
            w_next_state = S_RD_REQ;
          end else begin
`ifdef AVALON_MEM_BIST_INVERT_PASS_EN
            w_next_state = r_pass_idx ? S_FIN : S_WR;
`else
            w_next_state = S_FIN;
`endif
          end
        end
      end
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base          <= '0;
      r_len           <= '0;
      r_seed          <= '0;
      r_idx           <= '0;
      r_lat           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      error_count     <= '0;
      first_fail_addr <= '0;
`ifdef AVALON_MEM_BIST_INVERT_PASS_EN
      r_pass_idx      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base          <= base_addr;
            r_len           <= w_len_clamped;
            r_seed          <= seed;
            r_idx           <= '0;
            busy            <= 1'b1;
            pass            <= 1'b0;
            error_count     <= '0;
            first_fail_addr <= '0;
`ifdef AVALON_MEM_BIST_INVERT_PASS_EN
            r_pass_idx      <= 1'b0;
`endif
          end
        end
        S_WR: begin
          if (!avm_waitrequest) r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
        S_RD_REQ: begin
          if (!avm_waitrequest) r_lat <= 3'd1;
        end
        S_RD_WAIT: begin
          if (w_sample) begin
            if (w_mismatch) begin
              // A zero count means this is the first mismatch of the test.
              if (error_count == '0) first_fail_addr <= w_addr;
              if (error_count != {ERR_W{1'b1}}) error_count <= error_count + 1'b1;
            end
            r_idx <= w_last ? '0 : r_idx + 1'b1;
`ifdef AVALON_MEM_BIST_INVERT_PASS_EN
            if (w_last) r_pass_idx <= 1'b1;
`endif
          end else begin
            r_lat <= r_lat + 3'd1;
          end
        end
        S_FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
          pass <= (error_count == '0);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avalon_mem_bist_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_avalon_mem_bist_master                                                |
// | Scoreboard bench: reference model fills queues, negedge monitor checks.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_avalon_mem_bist_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] base_addr = '0;
  logic [14:0] length = '0;
  logic [31:0] seed = '0;
  logic        busy, done, pass;
  logic [15:0] error_count;
  logic [13:0] first_fail_addr, avm_address;
  logic        avm_chipselect, avm_write, avm_read;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;

  avalon_mem_bist_master dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .first_fail_addr(first_fail_addr),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write(avm_write), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

`ifdef AVALON_MEM_BIST_INVERT_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  typedef struct { logic [13:0] a; logic [31:0] d; } wr_t;
  typedef struct { bit ok; int err; logic [13:0] ffa; int cyc; } res_t;

  wr_t         exp_wr_q[$];
  logic [13:0] exp_rd_q[$];
  res_t        exp_res_q[$];

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int busy_cycles = 0;

  bit          stall_en = 0;
  bit          cor_en = 0;
  logic [13:0] cor_addr = '0;
  logic [31:0] mem [0:16383];
  bit          rd_pend = 0;
  logic [31:0] rd_data = '0;
  bit          prev_stall = 0;
  logic [52:0] prev_vec = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: accepts at the negedge view of the cycle, returns read data the cycle after.
  always @(negedge clk) begin
    if (!reset_n) rd_pend = 0;
    else if (avm_chipselect && !avm_waitrequest) begin
      if (avm_write) mem[avm_address] = avm_writedata;
      if (avm_read) begin
        rd_pend = 1;
        rd_data = (cor_en && avm_address == cor_addr) ? 32'h0 : mem[avm_address];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rd_pend) begin
      avm_readdata = rd_data;
      rd_pend = 0;
    end else begin
      avm_readdata = $urandom;
    end
    avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Monitor
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall  = 0;
      busy_cycles = 0;
    end else begin
      if (prev_stall)
        chk("stall_hold", 64'({avm_chipselect, avm_write, avm_read, avm_byteenable,
                               avm_address, avm_writedata}), 64'(prev_vec));
      prev_stall = avm_chipselect && avm_waitrequest;
      prev_vec   = {avm_chipselect, avm_write, avm_read, avm_byteenable, avm_address, avm_writedata};
      if (avm_chipselect) begin
        chk("byteenable", 64'(avm_byteenable), 64'hF);
        if (exp_wr_q.size() == 0 && exp_rd_q.size() == 0)
          chk("unexpected_chipselect", 64'(avm_chipselect), 64'h0);
      end
      if (avm_chipselect && avm_write && !avm_waitrequest) begin
        if (exp_wr_q.size() == 0) chk("extra_write", 64'(avm_address), 64'hFFFF_FFFF);
        else begin
          wr_t w;
          w = exp_wr_q.pop_front();
          chk("wr_addr", 64'(avm_address), 64'(w.a));
          chk("wr_data", 64'(avm_writedata), 64'(w.d));
        end
      end
      if (avm_chipselect && avm_read && !avm_waitrequest) begin
        if (exp_rd_q.size() == 0) chk("extra_read", 64'(avm_address), 64'hFFFF_FFFF);
        else chk("rd_addr", 64'(avm_address), 64'(exp_rd_q.pop_front()));
      end
      if (busy) busy_cycles++;
      if (done) begin
        done_cnt++;
        if (exp_res_q.size() == 0) chk("unexpected_done", 64'(done), 64'h0);
        else begin
          res_t r;
          r = exp_res_q.pop_front();
          chk("pass", 64'(pass), 64'(r.ok));
          chk("error_count", 64'(error_count), 64'(r.err));
          chk("first_fail_addr", 64'(first_fail_addr), 64'(r.ffa));
          chk("busy_at_done", 64'(busy), 64'h0);
          chk("words_left", 64'(exp_wr_q.size() + exp_rd_q.size()), 64'h0);
          if (r.cyc >= 0) chk("busy_cycles", 64'(busy_cycles), 64'(r.cyc));
        end
        busy_cycles = 0;
      end
    end
  end

  // Reference model: expected bus traffic and result derived from the pattern rules.
  task automatic expect_test(input logic [13:0] b, input logic [14:0] len, input logic [31:0] s,
                             input bit stall);
    int n, errs;
    logic [13:0] a, ffa;
    logic [31:0] p;
    res_t r;
    n = (len > 15'h4000) ? 16384 : int'(len);
    errs = 0;
    ffa = '0;
    for (int pi = 0; pi < NPASS; pi++) begin
      for (int i = 0; i < n; i++) begin
        a = b + 14'(i);
        p = s + 32'(i);
        if (pi == 1) p = ~p;
        exp_wr_q.push_back('{a: a, d: p});
      end
      for (int i = 0; i < n; i++) begin
        a = b + 14'(i);
        p = s + 32'(i);
        if (pi == 1) p = ~p;
        exp_rd_q.push_back(a);
        if (cor_en && a == cor_addr && p != 32'h0) begin
          if (errs == 0) ffa = a;
          errs++;
        end
      end
    end
    r.ok  = (errs == 0);
    r.err = errs;
    r.ffa = ffa;
    r.cyc = stall ? -1 : ((n == 0) ? 1 : NPASS * 3 * n + 1);
    exp_res_q.push_back(r);
  endtask

  task automatic pulse_start(input logic [13:0] b, input logic [14:0] len, input logic [31:0] s);
    @(posedge clk); #1;
    base_addr = b; length = len; seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 14'($urandom); length = 15'($urandom); seed = $urandom;
  endtask

  task automatic run_test(input logic [13:0] b, input logic [14:0] len, input logic [31:0] s,
                          input bit stall, input bit restart);
    int target;
    stall_en = stall;
    target = done_cnt + 1;
    expect_test(b, len, s, stall);
    pulse_start(b, len, s);
    if (restart) begin
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int c = 0; c < 20000 && done_cnt < target; c++) @(posedge clk);
    if (done_cnt < target) begin
      chk("done_timeout", 64'(done_cnt), 64'(target));
      exp_wr_q.delete(); exp_rd_q.delete(); exp_res_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [13:0] b;
    logic [14:0] len;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_chipselect", 64'(avm_chipselect), 64'h0);
    chk("rst_strobes", 64'({avm_write, avm_read, avm_byteenable}), 64'h0);
    chk("rst_addr_data", 64'({avm_address, avm_writedata}), 64'h0);
    chk("rst_status", 64'({busy, done, pass}), 64'h0);
    chk("rst_err_ffa", 64'({error_count, first_fail_addr}), 64'h0);
    reset_n = 1'b1;

    run_test(14'h0010, 15'd4, 32'hA5A5_0000, 0, 0);

    cor_en = 1; cor_addr = 14'h0012;
    run_test(14'h0010, 15'd4, 32'hA5A5_0000, 0, 0);
    cor_en = 0;

    for (int k = 0; k < 5; k++)
      run_test(14'($urandom), 15'($urandom_range(1, 40)), $urandom, 1, k[0]);

    run_test(14'h3FFE, 15'd4, 32'h1234_5678, 0, 0);
    run_test(14'h0100, 15'd0, 32'hDEAD_BEEF, 0, 0);

    // Reset during the second write beat, then a clean test.
    stall_en = 0;
    expect_test(14'h0200, 15'd8, 32'h0000_1000, 0);
    pulse_start(14'h0200, 15'd8, 32'h0000_1000);
    @(posedge clk); #2;
    chk("beat2_write", 64'({avm_write, avm_address}), 64'({1'b1, 14'h0201}));
    reset_n = 1'b0;
    #1;
    chk("arst_strobes", 64'({avm_chipselect, avm_write, avm_read, avm_byteenable}), 64'h0);
    chk("arst_status", 64'({busy, pass, done}), 64'h0);
    exp_wr_q.delete(); exp_rd_q.delete(); exp_res_q.delete();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    run_test(14'h0200, 15'd8, 32'h0000_1000, 0, 0);

    for (int k = 0; k < 4; k++) begin
      b = 14'($urandom);
      len = 15'($urandom_range(1, 30));
      cor_en = 1;
      cor_addr = b + 14'($urandom_range(0, int'(len) - 1));
      run_test(b, len, $urandom, 1, 1);
    end
    cor_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
